// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: sequences a divide-by-100 prescaler,
// counts its ticks down from a latched interval and pulses done on expiry.
module interval_timer_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             div_ena,
    output logic             div_clr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] w_reload_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_expire;
    logic             r_div_ena;
    logic             r_div_clr;
    logic             r_busy;

    // State register plus datapath; Moore outputs are registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_reload    <= '0;
            r_done      <= 1'b0;
            r_div_ena   <= 1'b0;
            r_div_clr   <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_reload    <= w_reload_nxt;
            r_done      <= w_done_nxt;
            r_div_ena   <= (w_state_nxt == S_RUN);
            r_div_clr   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ARM);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state and datapath decode; clear beats stop beats start
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_reload_nxt    = r_reload;
        w_done_nxt      = 1'b0;
        w_expire        = 1'b0;

        if (clear) begin
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        if (load_val != '0) begin
                            w_reload_nxt    = load_val;
                            w_remaining_nxt = load_val;
                            w_state_nxt     = S_ARM;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (tick) begin
                        if (r_remaining > CNT_W'(1)) begin
                            w_remaining_nxt = r_remaining - CNT_W'(1);
                        end else if (r_remaining == CNT_W'(1)) begin
                            w_expire   = 1'b1;
                            w_done_nxt = 1'b1;
                            // Periodic reload skips ARM so the prescaler phase carries over
                            if (periodic) begin
                                w_remaining_nxt = r_reload;
                            end else begin
                                w_remaining_nxt = '0;
                                w_state_nxt     = S_IDLE;
                            end
                        end
                    end
                    if (stop && !w_expire) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign div_ena   = r_div_ena;
    assign div_clr   = r_div_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl driving a behavioural divide-by-100
// prescaler; inputs and checks happen on the falling clock edge.
module tb_interval_timer_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             start    = 1'b0;
    logic             stop     = 1'b0;
    logic             clear    = 1'b0;
    logic             periodic = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic             tick;
    logic             div_ena;
    logic             div_clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int m_cnt       = 0;
    int n_vec       = 0;
    int n_err       = 0;
    int ena_cycles  = 0;
    int clr_cycles  = 0;
    int done_cycles = 0;
    int n;

    interval_timer_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .periodic  (periodic),
        .load_val  (load_val),
        .tick      (tick),
        .div_ena   (div_ena),
        .div_clr   (div_clr),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Divide-by-100 prescaler model: tick while enabled on the last phase count
    always_ff @(posedge clk) begin
        if (div_clr)
            m_cnt <= 0;
        else if (div_ena)
            m_cnt <= (m_cnt == 99) ? 0 : m_cnt + 1;
    end
    assign tick = div_ena && (m_cnt == 99);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        if (div_ena) ena_cycles++;
        if (div_clr) clr_cycles++;
        if (done)    done_cycles++;
        @(negedge clk);
    endtask

    task automatic clear_stats();
        ena_cycles  = 0;
        clr_cycles  = 0;
        done_cycles = 0;
    endtask

    task automatic run_until_done(input int max, output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < max) begin
            cycle();
            cnt++;
        end
    endtask

    // Start from IDLE and return on the first falling edge in RUN
    task automatic launch(input logic [CNT_W-1:0] v, input logic per);
        load_val = v;
        periodic = per;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_clr",  32'(div_clr), 32'd1);
        chk("arm_ena",  32'(div_ena), 32'd0);
        chk("arm_rem",  32'(remaining), 32'(v));
        cycle();
        chk("run_ena",  32'(div_ena), 32'd1);
        chk("run_clr",  32'(div_clr), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ena",  32'(div_ena), 32'd0);
        chk("rst_clr",  32'(div_clr), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rem",  32'(remaining), 32'd0);
        rst = 1'b1;
        cycle();

        // One-shot, 3 ticks
        launch(8'd3, 1'b0);
        clear_stats();
        repeat (150) cycle();
        chk("os_rem2", 32'(remaining), 32'd2);
        repeat (100) cycle();
        chk("os_rem1", 32'(remaining), 32'd1);
        run_until_done(200, n);
        chk("os_lat",  32'(n), 32'd50);
        chk("os_busy", 32'(busy), 32'd0);
        chk("os_rem0", 32'(remaining), 32'd0);
        chk("os_ena",  32'(div_ena), 32'd0);
        chk("os_clr",  32'(div_clr), 32'd1);
        cycle();
        chk("os_done_1c", 32'(done), 32'd0);

        // Periodic, 2 ticks per interval; start pulse and new load_val mid-run are ignored
        launch(8'd2, 1'b1);
        clear_stats();
        run_until_done(400, n);
        chk("per_first", 32'(n), 32'd200);
        chk("per_reload", 32'(remaining), 32'd2);
        chk("per_busy", 32'(busy), 32'd1);
        load_val = 8'd7;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        chk("per_done_1c", 32'(done), 32'd0);
        run_until_done(400, n);
        chk("per_gap2", 32'(n), 32'd199);
        cycle();
        run_until_done(400, n);
        chk("per_gap3", 32'(n), 32'd199);
        chk("per_rem",  32'(remaining), 32'd2);
        chk("per_noclr", 32'(clr_cycles), 32'd0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("per_clr_busy", 32'(busy), 32'd0);
        chk("per_clr_rem",  32'(remaining), 32'd0);
        chk("per_clr_done", 32'(done), 32'd0);
        chk("per_clr_div",  32'(div_clr), 32'd1);

        // Pause and resume, 5 ticks
        launch(8'd5, 1'b0);
        clear_stats();
        repeat (250) cycle();
        chk("pz_rem_pre", 32'(remaining), 32'd3);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("pz_ena",  32'(div_ena), 32'd0);
        chk("pz_clr",  32'(div_clr), 32'd0);
        chk("pz_busy", 32'(busy), 32'd1);
        repeat (50) cycle();
        chk("pz_rem_hold", 32'(remaining), 32'd3);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("pz_resume", 32'(div_ena), 32'd1);
        run_until_done(600, n);
        chk("pz_done",     32'(done), 32'd1);
        chk("pz_ena_clks", 32'(ena_cycles), 32'd500);
        chk("pz_idle",     32'(busy), 32'd0);
        cycle();

        // Stop coincident with the final tick: expiry wins, lands in IDLE
        launch(8'd1, 1'b0);
        n = 0;
        while (tick !== 1'b1 && n < 300) begin
            cycle();
            n++;
        end
        chk("st_tick_at", 32'(n), 32'd99);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("st_done", 32'(done), 32'd1);
        chk("st_busy", 32'(busy), 32'd0);
        chk("st_clr",  32'(div_clr), 32'd1);
        chk("st_rem",  32'(remaining), 32'd0);
        cycle();
        chk("st_done_1c", 32'(done), 32'd0);

        // Clear and start together in RUN
        launch(8'd4, 1'b0);
        repeat (30) cycle();
        clear = 1'b1;
        start = 1'b1;
        cycle();
        clear = 1'b0;
        start = 1'b0;
        chk("cs_busy", 32'(busy), 32'd0);
        chk("cs_done", 32'(done), 32'd0);
        chk("cs_rem",  32'(remaining), 32'd0);
        clear_stats();
        repeat (150) cycle();
        chk("cs_no_done", 32'(done_cycles), 32'd0);
        chk("cs_no_ena",  32'(ena_cycles), 32'd0);

        // Zero interval: immediate done, never leaves IDLE
        load_val = 8'd0;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        chk("z_done", 32'(done), 32'd1);
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_ena",  32'(div_ena), 32'd0);
        chk("z_rem",  32'(remaining), 32'd0);
        cycle();
        chk("z_done_1c", 32'(done), 32'd0);
        chk("z_busy_1c", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        launch(8'd3, 1'b0);
        repeat (20) cycle();
        chk("ar_rem_pre", 32'(remaining), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ena",  32'(div_ena), 32'd0);
        chk("ar_clr",  32'(div_clr), 32'd1);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_rem",  32'(remaining), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("ar_post_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
- Controller that sequences the divide-by-100 prescaler (ena/clear inputs, one-cycle tick output) to build a programmable interval timer.
- Drives the prescaler's enable and clear, counts its ticks down from a loaded value and pulses done on expiry; one-shot or periodic.
- Sits between the user-facing start/stop/clear controls and the prescaler instance in the lab timer top level.

Parameters:
CNT_W, 8, width of the interval count (ticks) and remaining-count output.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  level, sampled each clock; begin/resume timing
stop  input  1  level; pause timing (prescaler phase held)
clear  input  1  level; abort to idle
periodic  input  1  1 = auto-reload on expiry, 0 = one-shot
load_val  input  CNT_W  interval in prescaler ticks, latched on start from IDLE
tick  input  1  one-cycle pulse from prescaler
div_ena  output  1  prescaler enable
div_clr  output  1  prescaler synchronous clear
busy  output  1  1 when state != IDLE
done  output  1  registered one-cycle expiry pulse
remaining  output  CNT_W  ticks left in current interval

Behaviour:
- Reset (rst=0, async): state IDLE, remaining=0, reload=0, done=0. Outputs therefore div_ena=0, div_clr=1, busy=0.
- States: IDLE, ARM, RUN, PAUSE.
- Moore outputs decoded from state:
  - div_ena=1 only in RUN.
  - div_clr=1 in IDLE and ARM, 0 otherwise.
  - busy=0 only in IDLE.
- Input priority each cycle: clear > stop > start.
- IDLE:
  - start & load_val!=0: latch reload<=load_val, remaining<=load_val, go to ARM.
  - start & load_val==0: done=1 next cycle, stay IDLE, remaining unchanged.
- ARM: exactly one cycle; prescaler held in clear so its phase restarts at 0. Go to RUN unconditionally unless clear.
- RUN (tick sampled only here; ignored in every other state):
  - tick & remaining>1: remaining<=remaining-1.
  - tick & remaining==1: done<=1 for one cycle.
    - periodic=1: remaining<=reload, stay RUN. No ARM, so the prescaler phase continues and the period is exact.
    - periodic=0: remaining<=0, go to IDLE.
  - stop: go to PAUSE. A tick in the same cycle is still applied first; if it expires the interval, expiry wins (done pulses, next state follows the expiry rule above).
- PAUSE:
  - div_ena=0, div_clr=0: prescaler phase and remaining both held.
  - start & !stop: return to RUN.
- clear in any state: next state IDLE, remaining<=0, no done pulse. reload is retained.
- start held while RUN: no effect; no re-latch of load_val.
- load_val changes after latching: no effect until the next start from IDLE.
- periodic is sampled at each expiry, so it may change mid-run.
- done is never asserted in two consecutive cycles except via repeated start with load_val==0 in IDLE.
- Arithmetic: remaining is unsigned CNT_W and never decremented below 1 by a tick; no wrap.
- Latency:
  - start in IDLE to div_ena=1: 2 clocks (ARM, then RUN).
  - expiry tick to done: 1 clock.

Test Plan:
- Reset mid-RUN (remaining=3): assert rst=0 asynchronously -> immediately state IDLE, div_ena=0, div_clr=1, busy=0, done=0, remaining=0.
- One-shot, prescaler model /100, load_val=3, periodic=0, start pulse -> ARM 1 cycle, div_ena high, remaining 3->2->1 at each tick, done one cycle after the 3rd tick (~301 clocks after RUN entry), then IDLE, busy=0.
- Periodic, load_val=2, run 3 intervals -> done pulses exactly 200 clocks apart, remaining reloads to 2, div_clr never reasserted after ARM.
- Pause/resume, load_val=5: stop after 2 ticks -> PAUSE, remaining=3, div_ena=0, div_clr=0 held 50 cycles; start -> RUN, done after 3 more ticks, total enabled clocks = 500.
- Simultaneous events:
  - stop coincident with final tick, periodic=0 -> done pulses, state IDLE (not PAUSE).
  - clear+start together in RUN -> IDLE, no done.
- load_val=0 with start in IDLE -> single done pulse next cycle, busy stays 0, div_ena stays 0.
